// File: rtl/mppt_pkg.sv
// Shared types and helpers for the perturb-and-observe MPPT controller.
// Holds the FSM state encoding, the direction constants and a clamp helper.
package mppt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        WAIT_SAMPLE,
        COMPUTE,
        DECIDE,
        APPLY
    } mppt_state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    function automatic int clamp_int(input int val, input int lo, input int hi);
        if (val < lo) begin
            return lo;
        end
        if (val > hi) begin
            return hi;
        end
        return val;
    endfunction

endpackage

// File: rtl/mppt_settle_timer.sv
// Loadable down-counter that times the settling interval after a duty change.
// done is high once the loaded interval of CYCLES cycles has elapsed.
module mppt_settle_timer #(
    parameter int CYCLES = 2000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    output logic done
);

    localparam int CNT_W = (CYCLES < 1) ? 1 : $clog2(CYCLES + 1);

    logic [CNT_W-1:0] count;

    // Loading CYCLES-1 makes done rise in the CYCLES-th cycle after the load edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(CYCLES - 1);
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/mppt_po_controller.sv
// Perturb-and-observe MPPT controller driving the PWM duty word.
// Define MPPT_ADAPT_STEP_EN to enable the adaptive perturbation step size.
module mppt_po_controller
    import mppt_pkg::*;
#(
    parameter int DATA_W     = 12,
    parameter int DUTY_W     = 6,
    parameter int PERIOD     = 40,
    parameter int DUTY_MIN   = 4,
    parameter int DUTY_MAX   = 36,
    parameter int DUTY_INIT  = 20,
    parameter int STEP       = 1,
    parameter int SETTLE_CYC = 2000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [DATA_W-1:0]     v_in,
    input  logic [DATA_W-1:0]     i_in,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    input  logic                  period_start,
    output logic [DUTY_W-1:0]     duty,
    output logic                  duty_update,
    output logic [2*DATA_W-1:0]   pwr_out,
    output logic                  dir_out,
    output logic                  busy
);

    localparam int STEP_W = $clog2(STEP * 8 + 1);
    localparam logic [DUTY_W-1:0] DUTY_RST = DUTY_W'(clamp_int(DUTY_INIT, DUTY_MIN, DUTY_MAX));

    mppt_state_t state, state_nxt;

    logic                timer_load;
    logic                timer_done;
    logic [DATA_W-1:0]   v_lat;
    logic [DATA_W-1:0]   i_lat;
    logic [2*DATA_W-1:0] product;
    logic [2*DATA_W-1:0] p_prev;
    logic                p_valid;
    logic [DUTY_W-1:0]   duty_pend;
    logic [STEP_W-1:0]   step_cur;
    logic                dir_eval;
    logic                dir_dec;
    logic [DUTY_W-1:0]   duty_dec;
    int                  duty_raw;

    mppt_settle_timer #(
        .CYCLES(SETTLE_CYC)
    ) u_settle (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (timer_load),
        .done   (timer_done)
    );

    assign product = {{DATA_W{1'b0}}, v_lat} * {{DATA_W{1'b0}}, i_lat};

    always_comb begin
        state_nxt  = state;
        timer_load = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt  = SETTLE;
                    timer_load = 1'b1;
                end
                SETTLE:      if (timer_done) state_nxt = WAIT_SAMPLE;
                WAIT_SAMPLE: if (sample_valid) state_nxt = COMPUTE;
                COMPUTE:     state_nxt = DECIDE;
                DECIDE:      state_nxt = APPLY;
                APPLY: begin
                    if (period_start) begin
                        state_nxt  = SETTLE;
                        timer_load = 1'b1;
                    end
                end
                default:     state_nxt = IDLE;
            endcase
        end
    end

    // Direction and saturated duty for the DECIDE cycle; hitting a bound reverses the next move.
    always_comb begin
        dir_eval = dir_out;
        if (p_valid && (pwr_out < p_prev)) begin
            dir_eval = (dir_out == DIR_UP) ? DIR_DN : DIR_UP;
        end
        duty_raw = (dir_eval == DIR_UP) ? (int'(duty) + int'(step_cur))
                                        : (int'(duty) - int'(step_cur));
        dir_dec  = dir_eval;
        duty_dec = DUTY_W'(clamp_int(duty_raw, DUTY_MIN, DUTY_MAX));
        if ((duty_raw > DUTY_MAX) || (duty_raw < DUTY_MIN)) begin
            dir_dec = (dir_eval == DIR_UP) ? DIR_DN : DIR_UP;
        end
    end

`ifdef MPPT_ADAPT_STEP_EN
    localparam logic [STEP_W-1:0] STEP_LO    = STEP_W'(STEP);
    localparam logic [STEP_W-1:0] STEP_HI    = STEP_W'(STEP * 8);
    localparam logic [STEP_W-1:0] STEP_START = STEP_W'(STEP * 4);

    logic [STEP_W-1:0] step_q;
    logic [1:0]        same_cnt;

    assign step_cur = step_q;

    // Shrink on any reversal, grow after four decisions in a row keep the same direction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_q   <= STEP_START;
            same_cnt <= '0;
        end else if (!enable) begin
            step_q   <= STEP_START;
            same_cnt <= '0;
        end else if (state == DECIDE) begin
            if (dir_dec != dir_out) begin
                step_q   <= ((step_q >> 1) < STEP_LO) ? STEP_LO : (step_q >> 1);
                same_cnt <= '0;
            end else if (same_cnt == 2'd3) begin
                step_q   <= (step_q > (STEP_HI >> 1)) ? STEP_HI : (step_q << 1);
                same_cnt <= '0;
            end else begin
                same_cnt <= same_cnt + 2'd1;
            end
        end
    end
`else
    assign step_cur = STEP_W'(STEP);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            duty         <= DUTY_RST;
            duty_pend    <= DUTY_RST;
            duty_update  <= 1'b0;
            sample_ready <= 1'b0;
            pwr_out      <= '0;
            dir_out      <= DIR_UP;
            busy         <= 1'b0;
            p_prev       <= '0;
            p_valid      <= 1'b0;
            v_lat        <= '0;
            i_lat        <= '0;
        end else begin
            state        <= state_nxt;
            sample_ready <= (state_nxt == WAIT_SAMPLE);
            busy         <= (state_nxt != IDLE);
            duty_update  <= 1'b0;
            if (!enable) begin
                p_valid <= 1'b0;
            end else begin
                case (state)
                    WAIT_SAMPLE: begin
                        if (sample_valid) begin
                            v_lat <= v_in;
                            i_lat <= i_in;
                        end
                    end
                    COMPUTE: pwr_out <= product;
                    DECIDE: begin
                        dir_out   <= dir_dec;
                        duty_pend <= duty_dec;
                        p_prev    <= pwr_out;
                        p_valid   <= 1'b1;
                    end
                    APPLY: begin
                        if (period_start) begin
                            duty        <= duty_pend;
                            duty_update <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
